// File: rtl/haz_detect_unit_if.sv
// Hazard detection bus between the decode stage, the hazard unit and the resolver.
// The master side drives ID fields and resolver responses. The slave side is the
// hazard unit, which returns hazard requests and the accept signal.
interface haz_detect_unit_if #(
  parameter int REGW = 3
);
  logic            in_valid;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic [REGW-1:0] in_rd;
  logic            in_wr;
  logic            in_load;
  logic            in_mem;
  logic            in_branch;
  logic            mem_busy;
  logic            br_resolve;
  logic            br_ok;
  logic            stall_in;
  logic            flush_in;
  logic            haz_data;
  logic            haz_str;
  logic            haz_ctrl;
  logic            haz_branch;
  logic            haz_fwrd;
  logic            haz_crct;
  logic            in_ready;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_wr, in_load, in_mem, in_branch,
    output mem_busy, br_resolve, br_ok, stall_in, flush_in,
    input  haz_data, haz_str, haz_ctrl, haz_branch, haz_fwrd, haz_crct, in_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wr, in_load, in_mem, in_branch,
    input  mem_busy, br_resolve, br_ok, stall_in, flush_in,
    output haz_data, haz_str, haz_ctrl, haz_branch, haz_fwrd, haz_crct, in_ready
  );
endinterface

// File: rtl/haz_detect_unit.sv
// Hazard detection unit: tracks the EX and MEM occupants and raises data,
// structural and control hazard requests combinationally for the ID instruction.
// A branch in EX is held there until it resolves; a flush empties EX.
module haz_detect_unit #(
  parameter int REGW = 3
) (
  input  logic             clk,
  input  logic             rst,
  haz_detect_unit_if.slave hazBus
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_RES  = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            wr;
    logic            load;
    logic            mem;
    logic            branch;
  } stage_t;

  stage_t     exStage_q, exStage_d;
  stage_t     memStage_q, memStage_d;
  stage_t     idStage;
  logic [1:0] state_q, state_d;

  logic hitEx;
  logic hitMem;
  logic hitExLoad;
  logic hold;
  logic accept;
  logic branchEnter;
  logic resolveNow;
  logic unusedMemBits;

  // A stage produces a match only for a real, register-writing, non-zero destination.
  function automatic logic regHit(input logic [REGW-1:0] rs, input stage_t st);
    return st.valid && st.wr && (st.rd != '0) && (rs == st.rd);
  endfunction

  assign idStage = {1'b1, hazBus.in_rd, hazBus.in_wr, hazBus.in_load,
                    hazBus.in_mem, hazBus.in_branch};

  assign hitEx      = regHit(hazBus.in_rs1, exStage_q) || regHit(hazBus.in_rs2, exStage_q);
  assign hitMem     = regHit(hazBus.in_rs1, memStage_q) || regHit(hazBus.in_rs2, memStage_q);
  assign hitExLoad  = hitEx && exStage_q.load;
  assign resolveNow = (state_q == C_WAIT) && hazBus.br_resolve;
  assign hold       = (state_q == C_WAIT) && exStage_q.valid && exStage_q.branch
                      && !hazBus.br_resolve;
  assign accept     = !rst && hazBus.in_valid && !hazBus.stall_in && !hazBus.flush_in && !hold;
  assign branchEnter = accept && hazBus.in_branch;

  // The MEM load/branch flags only travel along with the stage; nothing reads them there.
  assign unusedMemBits = memStage_q.load ^ memStage_q.branch;

  // Hazard requests are pure functions of current state and inputs, forced idle during reset.
  always_comb begin
    hazBus.haz_data   = !rst && hazBus.in_valid && (hitEx || hitMem);
    hazBus.haz_fwrd   = !rst && hazBus.in_valid && (hitEx || hitMem) && !hitExLoad;
    hazBus.haz_str    = !rst && hazBus.in_valid && hazBus.in_mem
                        && ((memStage_q.valid && memStage_q.mem) || hazBus.mem_busy);
    hazBus.haz_ctrl   = !rst && ((state_q == C_WAIT) || (state_q == C_RES));
    hazBus.haz_branch = !rst && resolveNow;
    hazBus.haz_crct   = rst || !resolveNow || hazBus.br_ok;
    hazBus.in_ready   = accept;
  end

  // Next pipeline contents and branch-tracking state; flush beats hold, hold beats normal flow.
  always_comb begin
    exStage_d  = exStage_q;
    memStage_d = exStage_q;
    state_d    = state_q;
    if (hazBus.flush_in) begin
      exStage_d.valid = 1'b0;
      state_d         = C_IDLE;
    end else if (hold) begin
      memStage_d = '0;
    end else begin
      exStage_d = accept ? idStage : stage_t'('0);
      case (state_q)
        C_IDLE:  state_d = branchEnter ? C_WAIT : C_IDLE;
        C_WAIT:  state_d = hazBus.br_resolve ? C_RES : C_WAIT;
        C_RES:   state_d = branchEnter ? C_WAIT : C_IDLE;
        default: state_d = C_IDLE;
      endcase
    end
  end

  // Register the stages and FSM; reset empties the pipeline and returns to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      exStage_q  <= '0;
      memStage_q <= '0;
      state_q    <= C_IDLE;
    end else begin
      exStage_q  <= exStage_d;
      memStage_q <= memStage_d;
      state_q    <= state_d;
    end
  end

endmodule
